// File: rtl/epcs_flash_responder_if.sv
// EPCS serial link and backing-memory port bundle for epcs_flash_responder.
// The master modport is the environment side (SPI master plus byte memory);
// the slave modport is the flash responder itself.
interface epcs_flash_responder_if #(
    parameter int unsigned ADDR_W = 23
);
    logic              EPCS_DCLK;
    logic              EPCS_CSN;
    logic              EPCS_ASDI;
    logic              EPCS_DATA;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic              cmd_err;

    modport master (
        output EPCS_DCLK,
        output EPCS_CSN,
        output EPCS_ASDI,
        output mem_data,
        input  EPCS_DATA,
        input  mem_addr,
        input  mem_rd,
        input  cmd_err
    );

    modport slave (
        input  EPCS_DCLK,
        input  EPCS_CSN,
        input  EPCS_ASDI,
        input  mem_data,
        output EPCS_DATA,
        output mem_addr,
        output mem_rd,
        output cmd_err
    );
endinterface

// File: rtl/epcs_flash_responder.sv
// EPCS serial configuration flash responder: SPI slave running on SYS_CLK that
// oversamples DCLK, decodes READ (0x03) / READ STATUS (0x05) and serves bytes
// from a synchronous byte memory with one-byte prefetch.
// Optional: define EPCS_SILICON_ID_EN to support READ SILICON ID (0xAB).
module epcs_flash_responder #(
    parameter int unsigned ADDR_W     = 23,
    parameter logic [7:0]  STATUS_VAL = 8'h00
`ifdef EPCS_SILICON_ID_EN
    ,
    parameter logic [7:0]  SILICON_ID = 8'h16
`endif
) (
    input  logic                  SYS_CLK,
    input  logic                  SIM_RST,
    epcs_flash_responder_if.slave bus
);

    localparam int unsigned CNT_W    = 5;
    localparam int unsigned SHIFT_W  = 23;
    localparam int unsigned FADDR_W  = 24;
    localparam logic [7:0]  OP_READ   = 8'h03;
    localparam logic [7:0]  OP_STATUS = 8'h05;
`ifdef EPCS_SILICON_ID_EN
    localparam logic [7:0]  OP_SID    = 8'hAB;
`endif

    typedef enum logic [3:0] {
        S_WAIT_CS,
        S_IDLE,
        S_OPCODE,
        S_ADDR,
        S_DATA,
        S_STATUS,
        S_IGNORE
`ifdef EPCS_SILICON_ID_EN
        ,
        S_DUMMY,
        S_SID
`endif
    } state_e;

    // synchronisers
    logic dclk_s1_q, dclk_s2_q, dclk_s3_q;
    logic csn_s1_q, csn_s2_q;
    logic asdi_s1_q, asdi_s2_q;

    // FSM and datapath registers
    state_e              state_q,     state_d;
    logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [SHIFT_W-1:0]  shift_in_q,  shift_in_d;
    logic [7:0]          shift_out_q, shift_out_d;
    logic [7:0]          prefetch_q,  prefetch_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic                rd_pend_q,   rd_pend_d;
    logic                cap_pend_q,  cap_pend_d;
    logic                epcs_data_q, epcs_data_d;
    logic                mem_rd_q,    mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic                cmd_err_q,   cmd_err_d;

    logic                dclk_rise_c;
    logic                dclk_fall_c;
    logic [7:0]          opcode_c;
    logic [FADDR_W-1:0]  faddr_c;
    logic [7:0]          reload_c;

    // Two-flop synchronisers plus a third DCLK flop for edge detection.
    always_ff @(posedge SYS_CLK) begin
        if (SIM_RST) begin
            dclk_s1_q <= 1'b0;
            dclk_s2_q <= 1'b0;
            dclk_s3_q <= 1'b0;
            csn_s1_q  <= 1'b0;
            csn_s2_q  <= 1'b0;
            asdi_s1_q <= 1'b0;
            asdi_s2_q <= 1'b0;
        end else begin
            dclk_s1_q <= bus.EPCS_DCLK;
            dclk_s2_q <= dclk_s1_q;
            dclk_s3_q <= dclk_s2_q;
            csn_s1_q  <= bus.EPCS_CSN;
            csn_s2_q  <= csn_s1_q;
            asdi_s1_q <= bus.EPCS_ASDI;
            asdi_s2_q <= asdi_s1_q;
        end
    end

    assign dclk_rise_c = dclk_s2_q & ~dclk_s3_q;
    assign dclk_fall_c = ~dclk_s2_q & dclk_s3_q;
    assign opcode_c    = {shift_in_q[6:0], asdi_s2_q};
    assign faddr_c     = {shift_in_q, asdi_s2_q};

    // Byte loaded into the output shifter at the start of each served byte.
    always_comb begin
        reload_c = STATUS_VAL;
        if (state_q == S_DATA) begin
            reload_c = prefetch_q;
        end
`ifdef EPCS_SILICON_ID_EN
        else if (state_q == S_SID) begin
            reload_c = SILICON_ID;
        end
`endif
    end

    // State and datapath register update.
    always_ff @(posedge SYS_CLK) begin
        if (SIM_RST) begin
            state_q     <= S_WAIT_CS;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            prefetch_q  <= '0;
            addr_q      <= '0;
            rd_pend_q   <= 1'b0;
            cap_pend_q  <= 1'b0;
            epcs_data_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            prefetch_q  <= prefetch_d;
            addr_q      <= addr_d;
            rd_pend_q   <= rd_pend_d;
            cap_pend_q  <= cap_pend_d;
            epcs_data_q <= epcs_data_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // Next-state, shifting, prefetch and output logic.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        prefetch_d  = prefetch_q;
        addr_d      = addr_q;
        rd_pend_d   = rd_pend_q;
        cap_pend_d  = 1'b0;
        epcs_data_d = epcs_data_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        cmd_err_d   = 1'b0;

        if ((state_q != S_WAIT_CS) && csn_s2_q) begin
            // Deselect aborts everything, including any edge seen this cycle.
            state_d     = S_IDLE;
            bit_cnt_d   = '0;
            shift_in_d  = '0;
            shift_out_d = '0;
            rd_pend_d   = 1'b0;
            epcs_data_d = 1'b0;
        end else begin
            // Memory data is valid the cycle after the read strobe.
            cap_pend_d = mem_rd_q;
            if (cap_pend_q) begin
                prefetch_d = bus.mem_data;
                addr_d     = addr_q + ADDR_W'(1);
            end
            if (rd_pend_q) begin
                mem_rd_d   = 1'b1;
                mem_addr_d = addr_q;
                rd_pend_d  = 1'b0;
            end

            unique case (state_q)
                S_WAIT_CS: begin
                    epcs_data_d = 1'b0;
                    if (csn_s2_q) begin
                        state_d = S_IDLE;
                    end
                end

                S_IDLE: begin
                    epcs_data_d = 1'b0;
                    bit_cnt_d   = '0;
                    shift_in_d  = '0;
                    state_d     = S_OPCODE;
                end

                S_OPCODE: begin
                    epcs_data_d = 1'b0;
                    if (dclk_rise_c) begin
                        shift_in_d = {shift_in_q[SHIFT_W-2:0], asdi_s2_q};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            bit_cnt_d = '0;
                            if (opcode_c == OP_READ) begin
                                state_d = S_ADDR;
                            end else if (opcode_c == OP_STATUS) begin
                                state_d     = S_STATUS;
                                shift_out_d = STATUS_VAL;
                            end
`ifdef EPCS_SILICON_ID_EN
                            else if (opcode_c == OP_SID) begin
                                state_d = S_DUMMY;
                            end
`endif
                            else begin
                                cmd_err_d = 1'b1;
                                state_d   = S_IGNORE;
                            end
                        end
                    end
                end

                S_ADDR: begin
                    epcs_data_d = 1'b0;
                    if (dclk_rise_c) begin
                        shift_in_d = {shift_in_q[SHIFT_W-2:0], asdi_s2_q};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(23)) begin
                            bit_cnt_d  = '0;
                            addr_d     = ADDR_W'(faddr_c);
                            mem_addr_d = ADDR_W'(faddr_c);
                            mem_rd_d   = 1'b1;
                            state_d    = S_DATA;
                        end
                    end
                end

`ifdef EPCS_SILICON_ID_EN
                S_DUMMY: begin
                    epcs_data_d = 1'b0;
                    if (dclk_rise_c) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(23)) begin
                            bit_cnt_d   = '0;
                            shift_out_d = SILICON_ID;
                            state_d     = S_SID;
                        end
                    end
                end
`endif

                S_DATA, S_STATUS
`ifdef EPCS_SILICON_ID_EN
                , S_SID
`endif
                : begin
                    // Byte start loads the next byte; other falls shift MSB first.
                    if (dclk_fall_c) begin
                        if (bit_cnt_q == '0) begin
                            shift_out_d = reload_c;
                            epcs_data_d = reload_c[7];
                            rd_pend_d   = (state_q == S_DATA);
                        end else begin
                            shift_out_d = {shift_out_q[6:0], 1'b0};
                            epcs_data_d = shift_out_q[6];
                        end
                        bit_cnt_d = (bit_cnt_q == CNT_W'(7)) ? '0 : bit_cnt_q + CNT_W'(1);
                    end
                end

                S_IGNORE: begin
                    epcs_data_d = 1'b0;
                end

                default: begin
                    epcs_data_d = 1'b0;
                    state_d     = S_WAIT_CS;
                end
            endcase
        end
    end

    assign bus.EPCS_DATA = epcs_data_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_epcs_flash_responder.sv
// Self-checking bench for epcs_flash_responder: bit-banged SPI master (mode 3),
// synchronous byte memory, and scoreboards for MISO bytes and memory reads.
module tb_epcs_flash_responder;

    localparam int unsigned AW   = 23;
    localparam int unsigned H    = 10;
    localparam int unsigned MASK = (32'd1 << AW) - 32'd1;
    localparam logic [7:0]  STATUS_EXP = 8'h00;
`ifdef EPCS_SILICON_ID_EN
    localparam logic [7:0]  SID_EXP = 8'h16;
`endif

    logic SYS_CLK = 1'b0;
    logic SIM_RST = 1'b1;

    epcs_flash_responder_if #(.ADDR_W(AW)) bus ();

    epcs_flash_responder #(.ADDR_W(AW)) dut (
        .SYS_CLK (SYS_CLK),
        .SIM_RST (SIM_RST),
        .bus     (bus.slave)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]    exp_bytes[$];
    logic [AW-1:0] exp_addrs[$];
    logic [7:0]    mem_a[int unsigned];

    logic       rx_en = 1'b0;
    logic [7:0] rx_sh = 8'h00;
    int         rx_cnt = 0;
    int         rd_cnt = 0;
    int         cmd_err_cnt = 0;
    logic       prev_rd = 1'b0;
    logic       prev_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Flash contents: explicit entries, otherwise a fixed address hash.
    function automatic logic [7:0] byte_at(input int unsigned a);
        int unsigned k;
        k = a & MASK;
        if (mem_a.exists(k)) return mem_a[k];
        return 8'((k * 151 + 7) ^ (k >> 7));
    endfunction

    // Synchronous memory: data valid the cycle after mem_rd.
    always @(posedge SYS_CLK) begin
        if (bus.mem_rd) bus.mem_data <= byte_at(32'(bus.mem_addr));
    end

    // Monitor: memory reads and cmd_err pulses.
    always @(negedge SYS_CLK) begin
        if (bus.mem_rd) begin
            rd_cnt++;
            chk("mem_rd_back_to_back", 32'(prev_rd), 32'd0);
            if (exp_addrs.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mem_rd_unexpected: read at %0h, none required", bus.mem_addr);
            end else begin
                chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addrs.pop_front()));
            end
        end
        prev_rd = bus.mem_rd;
        if (bus.cmd_err) begin
            cmd_err_cnt++;
            chk("cmd_err_width", 32'(prev_err), 32'd0);
        end
        prev_err = bus.cmd_err;
    end

    // Monitor: MISO bytes sampled on DCLK rise during data phases.
    always @(posedge bus.EPCS_DCLK) begin
        if (!rx_en) begin
            rx_cnt = 0;
        end else begin
            rx_sh = {rx_sh[6:0], bus.EPCS_DATA};
            rx_cnt++;
            if (rx_cnt == 8) begin
                rx_cnt = 0;
                if (exp_bytes.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL miso_unexpected: byte %0h, none required", rx_sh);
                end else begin
                    chk("miso_byte", 32'(rx_sh), 32'(exp_bytes.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d errors", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge SYS_CLK);
    endtask

    task automatic clk_bit(input logic b);
        bus.EPCS_DCLK = 1'b0;
        bus.EPCS_ASDI = b;
        wait_clks(H);
        bus.EPCS_DCLK = 1'b1;
        wait_clks(H);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) clk_bit(b[i]);
    endtask

    task automatic cs_low();
        bus.EPCS_CSN = 1'b0;
        wait_clks(4);
    endtask

    task automatic cs_high();
        bus.EPCS_CSN = 1'b1;
        wait_clks(6);
    endtask

    task automatic rx_bytes(input int n);
        rx_en = 1'b1;
        repeat (n * 8) clk_bit(1'b0);
        rx_en = 1'b0;
    endtask

    task automatic drain_chk(input string nm);
        chk({nm, "_addr_q_left"}, 32'(exp_addrs.size()), 32'd0);
        chk({nm, "_byte_q_left"}, 32'(exp_bytes.size()), 32'd0);
    endtask

    // READ: n bytes from flash address fa; one prefetch plus one read per byte start.
    task automatic read_frame(input logic [23:0] fa, input int n);
        int unsigned base;
        int          rd0;
        base = 32'(fa) & MASK;
        rd0  = rd_cnt;
        for (int i = 0; i <= n; i++) exp_addrs.push_back(AW'((base + i) & MASK));
        for (int i = 0; i < n; i++)  exp_bytes.push_back(byte_at(base + i));
        cs_low();
        send_byte(8'h03);
        send_byte(fa[23:16]);
        send_byte(fa[15:8]);
        send_byte(fa[7:0]);
        rx_bytes(n);
        cs_high();
        chk("read_rd_count", 32'(rd_cnt - rd0), 32'(n + 1));
        drain_chk("read");
    endtask

    task automatic status_frame(input int n);
        int e0, rd0;
        e0 = cmd_err_cnt;
        rd0 = rd_cnt;
        for (int i = 0; i < n; i++) exp_bytes.push_back(STATUS_EXP);
        cs_low();
        send_byte(8'h05);
        rx_bytes(n);
        cs_high();
        chk("status_no_rd", 32'(rd_cnt - rd0), 32'd0);
        chk("status_no_cmd_err", 32'(cmd_err_cnt - e0), 32'd0);
        drain_chk("status");
    endtask

    task automatic bad_frame(input logic [7:0] op, input int n);
        int e0, rd0;
        e0 = cmd_err_cnt;
        rd0 = rd_cnt;
        for (int i = 0; i < n; i++) exp_bytes.push_back(8'h00);
        cs_low();
        send_byte(op);
        rx_bytes(n);
        cs_high();
        chk("bad_op_cmd_err", 32'(cmd_err_cnt - e0), 32'd1);
        chk("bad_op_no_rd", 32'(rd_cnt - rd0), 32'd0);
        drain_chk("bad_op");
    endtask

    initial begin
        int          rd0;
        logic        quiet;
        logic [23:0] fa;
        logic [7:0]  op;
        int          n;
        int unsigned base;

        bus.EPCS_DCLK = 1'b1;
        bus.EPCS_CSN  = 1'b1;
        bus.EPCS_ASDI = 1'b0;
        SIM_RST = 1'b1;
        wait_clks(4);
        chk("rst_miso", 32'(bus.EPCS_DATA), 32'd0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        SIM_RST = 1'b0;
        wait_clks(6);

        // Basic READ with explicit pattern.
        mem_a[32'h100] = 8'hA5;
        mem_a[32'h101] = 8'h3C;
        mem_a[32'h102] = 8'hFF;
        mem_a[32'h103] = 8'h00;
        read_frame(24'h000100, 4);

        // Address wrap at the top of the implemented space.
        mem_a[32'h7FFFFE] = 8'h11;
        mem_a[32'h7FFFFF] = 8'h22;
        mem_a[32'h0]      = 8'h33;
        read_frame(24'h7FFFFE, 3);

        status_frame(2);

        // Unsupported opcode, then a normal READ.
        bad_frame(8'h9F, 3);
        read_frame(24'h000200, 2);

        // Partial address discarded by deselect.
        rd0 = rd_cnt;
        cs_low();
        send_byte(8'h03);
        for (int i = 0; i < 12; i++) clk_bit(1'($urandom_range(0, 1)));
        cs_high();
        chk("partial_no_rd", 32'(rd_cnt - rd0), 32'd0);
        mem_a[32'h10] = 8'h5A;
        read_frame(24'h000010, 2);

        // Reset mid-DATA with CSN held low.
        base = 32'h300;
        for (int i = 0; i < 3; i++) exp_addrs.push_back(AW'(base + i));
        exp_bytes.push_back(byte_at(base));
        cs_low();
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h00);
        rx_bytes(1);
        for (int i = 0; i < 3; i++) clk_bit(1'b0);
        SIM_RST = 1'b1;
        wait_clks(2);
        SIM_RST = 1'b0;
        wait_clks(1);
        chk("rst_mid_miso", 32'(bus.EPCS_DATA), 32'd0);
        chk("rst_mid_mem_addr", 32'(bus.mem_addr), 32'd0);
        drain_chk("rst_mid");
        quiet = 1'b0;
        rd0 = rd_cnt;
        for (int i = 0; i < 16; i++) begin
            clk_bit(1'($urandom_range(0, 1)));
            quiet = quiet | bus.EPCS_DATA;
        end
        chk("rst_mid_quiet", 32'(quiet), 32'd0);
        chk("rst_mid_no_rd", 32'(rd_cnt - rd0), 32'd0);
        cs_high();
        read_frame(24'h000300, 2);

`ifdef EPCS_SILICON_ID_EN
        begin
            int e0;
            e0 = cmd_err_cnt;
            exp_bytes.push_back(SID_EXP);
            exp_bytes.push_back(SID_EXP);
            cs_low();
            send_byte(8'hAB);
            for (int i = 0; i < 3; i++) send_byte(8'($urandom));
            rx_bytes(2);
            cs_high();
            chk("sid_no_cmd_err", 32'(cmd_err_cnt - e0), 32'd0);
            drain_chk("sid");
        end
`else
        bad_frame(8'hAB, 2);
`endif

        // Randomised mix of frames.
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    fa = 24'($urandom);
                    if ($urandom_range(0, 3) == 0) fa[22:0] = 23'h7FFFFC | 23'($urandom_range(0, 3));
                    n = $urandom_range(1, 4);
                    base = 32'(fa) & MASK;
                    for (int i = 0; i <= n; i++) mem_a[(base + i) & MASK] = 8'($urandom);
                    read_frame(fa, n);
                end
                2: status_frame($urandom_range(1, 3));
                default: begin
                    op = 8'($urandom);
                    while (op == 8'h03 || op == 8'h05
`ifdef EPCS_SILICON_ID_EN
                           || op == 8'hAB
`endif
                          ) op = 8'($urandom);
                    bad_frame(op, $urandom_range(1, 2));
                end
            endcase
        end

        wait_clks(10);
        drain_chk("final");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
